// File: rtl/core_batch_scheduler_if.sv
// Bus between the batch scheduler and the core array / shared RAM.
// The scheduler takes the master modport, the core array the slave modport.
interface core_batch_scheduler_if #(
  parameter int NO_OF_CORES = 6,
  parameter int ROW_LEN     = 8,
  parameter int ADDRESS_LEN = 12
);
  logic [ADDRESS_LEN*NO_OF_CORES-1:0] core_addr;
  logic [NO_OF_CORES-1:0]             core_finish;
  logic [NO_OF_CORES-1:0]             core_read;
  logic [NO_OF_CORES-1:0]             core_write;
  logic [NO_OF_CORES-1:0]             core_start;
  logic [NO_OF_CORES-1:0]             core_reset;
  logic [ROW_LEN*NO_OF_CORES-1:0]     row_index;
  logic [NO_OF_CORES-1:0]             active_mask;
  logic                               ram_read;
  logic                               ram_write;

  modport master (
    input  core_addr, core_finish, core_read, core_write,
    output core_start, core_reset, row_index, active_mask, ram_read, ram_write
  );

  modport slave (
    output core_addr, core_finish, core_read, core_write,
    input  core_start, core_reset, row_index, active_mask, ram_read, ram_write
  );
endinterface

// File: rtl/core_batch_scheduler.sv
// Splits a programmed row count into batches of up to NO_OF_CORES rows, launches,
// aligns and staggers the cores of each batch, then re-arms them for the next one.
module core_batch_scheduler #(
  parameter int NO_OF_CORES  = 6,
  parameter int ROW_LEN      = 8,
  parameter int ADDRESS_LEN  = 12,
  parameter int SYNC_ADDR    = 5,
  parameter int HANDOFF_ADDR = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ROW_LEN-1:0]     no_of_rows,
  core_batch_scheduler_if.master cores,
  output logic                   busy,
  output logic [ROW_LEN-1:0]     batch_count,
  output logic                   finish_process
);
  localparam int KW = (NO_OF_CORES > 1) ? $clog2(NO_OF_CORES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_SYNC, S_STAGGER, S_RUN, S_REARM, S_DONE
  } state_t;

  state_t                         state_q;
  logic [ROW_LEN-1:0]             rem_q;
  logic [ROW_LEN-1:0]             base_q;
  logic [ROW_LEN-1:0]             n_q;
  logic [ROW_LEN-1:0]             batch_count_q;
  logic [KW-1:0]                  k_q;
  logic [NO_OF_CORES-1:0]         core_start_q;
  logic [NO_OF_CORES-1:0]         core_reset_q;
  logic [NO_OF_CORES-1:0]         mask_q;
  logic [ROW_LEN*NO_OF_CORES-1:0] row_index_q;

  logic [ROW_LEN-1:0]             n_d;
  logic [NO_OF_CORES-1:0]         mask_d;
  logic [ROW_LEN*NO_OF_CORES-1:0] row_index_d;
  logic [NO_OF_CORES-1:0]         sync_hit;
  logic [NO_OF_CORES-1:0]         handoff_hit;
  logic                           all_synced;
  logic                           all_finished;
  logic                           last_stage;

  assign n_d = (rem_q < ROW_LEN'(NO_OF_CORES)) ? rem_q : ROW_LEN'(NO_OF_CORES);

  for (genvar gi = 0; gi < NO_OF_CORES; gi++) begin : g_core
    assign mask_d[gi] = (ROW_LEN'(gi) < n_d);
    assign row_index_d[gi*ROW_LEN +: ROW_LEN] = base_q + ROW_LEN'(gi);
    assign sync_hit[gi] =
      (cores.core_addr[gi*ADDRESS_LEN +: ADDRESS_LEN] == ADDRESS_LEN'(SYNC_ADDR));
    assign handoff_hit[gi] =
      (cores.core_addr[gi*ADDRESS_LEN +: ADDRESS_LEN] == ADDRESS_LEN'(HANDOFF_ADDR));
  end

  // Inactive cores are forced to "satisfied" so they never hold up the batch.
  assign all_synced   = &(sync_hit | ~mask_q);
  assign all_finished = &(cores.core_finish | ~mask_q);
  assign last_stage   = (ROW_LEN'(k_q) == n_q - ROW_LEN'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      base_q        <= '0;
      n_q           <= '0;
      batch_count_q <= '0;
      k_q           <= '0;
      core_start_q  <= '0;
      core_reset_q  <= '0;
      mask_q        <= '0;
      row_index_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            rem_q         <= no_of_rows;
            base_q        <= '0;
            batch_count_q <= '0;
            mask_q        <= '0;
            core_start_q  <= '0;
            core_reset_q  <= '0;
            state_q       <= (no_of_rows == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          n_q           <= n_d;
          mask_q        <= mask_d;
          core_start_q  <= mask_d;
          row_index_q   <= row_index_d;
          rem_q         <= rem_q - n_d;
          batch_count_q <= batch_count_q + ROW_LEN'(1);
          state_q       <= S_SYNC;
        end
        S_SYNC: begin
          if (all_synced) begin
            core_start_q <= NO_OF_CORES'(1);
            k_q          <= '0;
            state_q      <= S_STAGGER;
          end
        end
        S_STAGGER: begin
          // Only one core runs at a time here; the baton moves one bit left per handoff.
          if (handoff_hit[k_q]) begin
            if (last_stage) begin
              core_start_q <= mask_q;
              state_q      <= S_RUN;
            end else begin
              core_start_q <= core_start_q << 1;
              k_q          <= k_q + KW'(1);
            end
          end
        end
        S_RUN: begin
          if (all_finished) begin
            core_start_q <= '0;
            if (rem_q != '0) begin
              core_reset_q <= mask_q;
              state_q      <= S_REARM;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_REARM: begin
          core_reset_q <= '0;
          base_q       <= base_q + n_q;
          state_q      <= S_LAUNCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign finish_process = (state_q == S_DONE);
  assign batch_count    = batch_count_q;

  assign cores.core_start  = core_start_q;
  assign cores.core_reset  = core_reset_q;
  assign cores.active_mask = mask_q;
  assign cores.row_index   = row_index_q;

  // Reads need agreement from every active core; any active writer drives a write.
  assign cores.ram_read  = busy && (|mask_q) && (&(cores.core_read | ~mask_q));
  assign cores.ram_write = busy && (|(cores.core_write & mask_q));
endmodule

// File: tb/tb_core_batch_scheduler.sv
// Directed bench for core_batch_scheduler with NO_OF_CORES=6: batching, stagger order,
// zero rows, RAM strobe merge, ignored start and asynchronous reset mid-stagger.
module tb_core_batch_scheduler;
  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] no_of_rows;
  logic       busy;
  logic [7:0] batch_count;
  logic       finish_process;

  int n_cmp;
  int n_err;

  core_batch_scheduler_if #(.NO_OF_CORES(6), .ROW_LEN(8), .ADDRESS_LEN(12)) bus ();

  core_batch_scheduler #(
    .NO_OF_CORES(6), .ROW_LEN(8), .ADDRESS_LEN(12), .SYNC_ADDR(5), .HANDOFF_ADDR(23)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .no_of_rows     (no_of_rows),
    .cores          (bus),
    .busy           (busy),
    .batch_count    (batch_count),
    .finish_process (finish_process)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addrs(input logic [11:0] all_val, input int hot);
    logic [71:0] v;
    for (int i = 0; i < 6; i++) v[i*12 +: 12] = all_val;
    if (hot >= 0) v[hot*12 +: 12] = 12'd23;
    bus.core_addr = v;
  endtask

  task automatic start_run(input logic [7:0] rows);
    no_of_rows = rows;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy got=%b exp=1", busy); end
    n_cmp++;
    if (bus.core_start !== 6'h00) begin
      n_err++; $display("FAIL start_core_start got=%h exp=00", bus.core_start);
    end
  endtask

  // Enters in LAUNCH; leaves in STAGGER with k=0.
  task automatic launch(input logic [5:0] mask, input logic [7:0] base, input logic [7:0] bc);
    logic [47:0] rows;
    for (int i = 0; i < 6; i++) rows[i*8 +: 8] = base + 8'(i);
    tick();
    $display("launch batch=%0d mask=%h base=%0d core_start=%h", batch_count,
             bus.active_mask, bus.row_index[7:0], bus.core_start);
    n_cmp++;
    if (bus.core_start !== mask) begin
      n_err++; $display("FAIL launch_core_start got=%h exp=%h", bus.core_start, mask);
    end
    n_cmp++;
    if (bus.active_mask !== mask) begin
      n_err++; $display("FAIL launch_mask got=%h exp=%h", bus.active_mask, mask);
    end
    n_cmp++;
    if (bus.row_index !== rows) begin
      n_err++; $display("FAIL launch_rows got=%h exp=%h", bus.row_index, rows);
    end
    n_cmp++;
    if (batch_count !== bc) begin
      n_err++; $display("FAIL launch_batch_count got=%0d exp=%0d", batch_count, bc);
    end
    // Addresses away from SYNC must hold the batch in SYNC.
    set_addrs(12'd4, -1);
    tick();
    n_cmp++;
    if (bus.core_start !== mask) begin
      n_err++; $display("FAIL sync_hold got=%h exp=%h", bus.core_start, mask);
    end
    set_addrs(12'd5, -1);
    tick();
    n_cmp++;
    if (bus.core_start !== 6'h01) begin
      n_err++; $display("FAIL sync_exit got=%h exp=01", bus.core_start);
    end
  endtask

  // Early finish is driven throughout the stagger and must not matter.
  task automatic stagger(input int n, input logic [5:0] mask);
    logic [5:0] exp;
    bus.core_finish = 6'h3F;
    for (int k = 0; k < n; k++) begin
      set_addrs(12'd5, k);
      tick();
      exp = (k == n - 1) ? mask : (6'h01 << (k + 1));
      $display("stagger k=%0d core_start=%h", k, bus.core_start);
      n_cmp++;
      if (bus.core_start !== exp) begin
        n_err++; $display("FAIL stagger_k%0d got=%h exp=%h", k, bus.core_start, exp);
      end
    end
    bus.core_finish = 6'h00;
    set_addrs(12'd0, -1);
  endtask

  task automatic finish_batch(input logic [5:0] mask, input bit last);
    bus.core_finish = mask;
    tick();
    bus.core_finish = 6'h00;
    if (!last) begin
      n_cmp++;
      if (bus.core_reset !== mask) begin
        n_err++; $display("FAIL rearm_reset got=%h exp=%h", bus.core_reset, mask);
      end
      n_cmp++;
      if (bus.core_start !== 6'h00 || busy !== 1'b1) begin
        n_err++; $display("FAIL rearm_state got=start %h busy %b exp=start 00 busy 1",
                          bus.core_start, busy);
      end
      tick();
      n_cmp++;
      if (bus.core_reset !== 6'h00) begin
        n_err++; $display("FAIL rearm_pulse_end got=%h exp=00", bus.core_reset);
      end
    end else begin
      n_cmp++;
      if (finish_process !== 1'b1 || busy !== 1'b0) begin
        n_err++; $display("FAIL done_flags got=finish %b busy %b exp=finish 1 busy 0",
                          finish_process, busy);
      end
      n_cmp++;
      if (bus.core_start !== 6'h00 || bus.core_reset !== 6'h00) begin
        n_err++; $display("FAIL done_cores got=start %h reset %h exp=00 00",
                          bus.core_start, bus.core_reset);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({busy, finish_process, batch_count, bus.core_start, bus.core_reset,
         bus.active_mask, bus.ram_read, bus.ram_write} !== 30'd0 ||
        bus.row_index !== 48'd0) begin
      n_err++;
      $display("FAIL %s got=busy %b fin %b bc %0d start %h reset %h mask %h rows %h rr %b rw %b exp=all 0",
               tag, busy, finish_process, batch_count, bus.core_start, bus.core_reset,
               bus.active_mask, bus.row_index, bus.ram_read, bus.ram_write);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.core_read = 6'h3F;
    bus.core_write = 6'h3F;
    #2;
    check_all_zero("reset_outputs");
    tick();
    tick();
    bus.core_read = 6'h00;
    bus.core_write = 6'h00;
    reset_n = 1'b1;
  endtask

  task automatic test_nineteen_rows();
    start_run(8'd19);
    launch(6'h3F, 8'd0, 8'd1);
    stagger(6, 6'h3F);
    finish_batch(6'h3F, 1'b0);
    launch(6'h3F, 8'd6, 8'd2);
    stagger(6, 6'h3F);
    finish_batch(6'h3F, 1'b0);
    launch(6'h3F, 8'd12, 8'd3);
    stagger(6, 6'h3F);
    finish_batch(6'h3F, 1'b0);
    launch(6'h01, 8'd18, 8'd4);
    stagger(1, 6'h01);
    finish_batch(6'h01, 1'b1);
    n_cmp++;
    if (batch_count !== 8'd4) begin
      n_err++; $display("FAIL rows19_batch_count got=%0d exp=4", batch_count);
    end
  endtask

  task automatic test_zero_rows();
    no_of_rows = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("zero-row start finish=%b busy=%b", finish_process, busy);
    n_cmp++;
    if (finish_process !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_flags got=finish %b busy %b exp=finish 1 busy 0",
                        finish_process, busy);
    end
    n_cmp++;
    if (batch_count !== 8'd0) begin
      n_err++; $display("FAIL zero_batch_count got=%0d exp=0", batch_count);
    end
    tick();
    n_cmp++;
    if (bus.core_start !== 6'h00) begin
      n_err++; $display("FAIL zero_core_start got=%h exp=00", bus.core_start);
    end
  endtask

  task automatic test_ram_merge_and_ignore();
    start_run(8'd8);
    launch(6'h3F, 8'd0, 8'd1);
    stagger(6, 6'h3F);
    finish_batch(6'h3F, 1'b0);
    launch(6'h03, 8'd6, 8'd2);
    stagger(2, 6'h03);
    bus.core_read  = 6'b000011;
    bus.core_write = 6'b110000;
    #1;
    n_cmp++;
    if (bus.ram_read !== 1'b1 || bus.ram_write !== 1'b0) begin
      n_err++; $display("FAIL merge_inactive got=rr %b rw %b exp=rr 1 rw 0",
                        bus.ram_read, bus.ram_write);
    end
    bus.core_read  = 6'b111101;
    bus.core_write = 6'b110010;
    #1;
    n_cmp++;
    if (bus.ram_read !== 1'b0 || bus.ram_write !== 1'b1) begin
      n_err++; $display("FAIL merge_active got=rr %b rw %b exp=rr 0 rw 1",
                        bus.ram_read, bus.ram_write);
    end
    // Inactive finishes plus a start pulse while running: nothing should move.
    bus.core_finish = 6'b111100;
    no_of_rows = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.core_finish = 6'b000100;
    tick();
    n_cmp++;
    if (bus.core_start !== 6'h03 || busy !== 1'b1 || batch_count !== 8'd2) begin
      n_err++; $display("FAIL run_ignore got=start %h busy %b bc %0d exp=start 03 busy 1 bc 2",
                        bus.core_start, busy, batch_count);
    end
    bus.core_read  = 6'h3F;
    bus.core_write = 6'h3F;
    finish_batch(6'h03, 1'b1);
    n_cmp++;
    if (bus.ram_read !== 1'b0 || bus.ram_write !== 1'b0 || batch_count !== 8'd2) begin
      n_err++; $display("FAIL done_ram got=rr %b rw %b bc %0d exp=rr 0 rw 0 bc 2",
                        bus.ram_read, bus.ram_write, batch_count);
    end
    bus.core_read  = 6'h00;
    bus.core_write = 6'h00;
  endtask

  task automatic test_reset_mid_stagger();
    start_run(8'd7);
    launch(6'h3F, 8'd0, 8'd1);
    set_addrs(12'd5, 0);
    tick();
    n_cmp++;
    if (bus.core_start !== 6'h02) begin
      n_err++; $display("FAIL pre_reset_stagger got=%h exp=02", bus.core_start);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    reset_n = 1'b1;
    set_addrs(12'd0, -1);
    start_run(8'd7);
    launch(6'h3F, 8'd0, 8'd1);
    stagger(6, 6'h3F);
    finish_batch(6'h3F, 1'b0);
    launch(6'h01, 8'd6, 8'd2);
    stagger(1, 6'h01);
    finish_batch(6'h01, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    start = 1'b0;
    no_of_rows = 8'd0;
    bus.core_finish = 6'h00;
    bus.core_read = 6'h00;
    bus.core_write = 6'h00;
    set_addrs(12'd0, -1);
    test_reset();
    test_nineteen_rows();
    test_zero_rows();
    test_ram_merge_and_ignore();
    test_reset_mid_stagger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
